// File: rtl/pipeline_controller_if.sv
// pipeline_controller_if: hazard/bus handshake bundle between the pipeline and its controller
//   id_stall_request, ex_stall_request : stage hazard requests
//   mem_request, bus_ready             : MEM bus access handshake
//   exception_valid, exception_handler_address : exception redirect request
//   stall[5:0], flush, new_pc, bus_timeout, stall_cycle_count : controller responses
//   master : pipeline side (drives requests); slave : controller side
interface pipeline_controller_if;
    logic        id_stall_request;
    logic        ex_stall_request;
    logic        mem_request;
    logic        bus_ready;
    logic        exception_valid;
    logic [31:0] exception_handler_address;
    logic [5:0]  stall;
    logic        flush;
    logic [31:0] new_pc;
    logic        bus_timeout;
    logic [31:0] stall_cycle_count;

    modport master (
        output id_stall_request, ex_stall_request, mem_request, bus_ready,
               exception_valid, exception_handler_address,
        input  stall, flush, new_pc, bus_timeout, stall_cycle_count
    );

    modport slave (
        input  id_stall_request, ex_stall_request, mem_request, bus_ready,
               exception_valid, exception_handler_address,
        output stall, flush, new_pc, bus_timeout, stall_cycle_count
    );
endinterface

// File: rtl/pipeline_controller.sv
// pipeline_controller: per-stage stall generation, bus-timeout abort FSM and flush/redirect control
//   clock : rising-edge clock
//   reset : synchronous, active-high
//   ctrl  : pipeline_controller_if.slave (hazard requests in; stall, flush, new_pc,
//           bus_timeout, stall_cycle_count out)
module pipeline_controller #(
    parameter int unsigned BUS_TIMEOUT_CYCLES = 256,
    parameter logic [31:0] BUS_ERROR_VECTOR   = 32'h0000_0180
) (
    input logic                  clock,
    input logic                  reset,
    pipeline_controller_if.slave ctrl
);
    typedef enum logic [1:0] {IDLE, WAIT, ABORT} state_t;

    localparam logic [15:0] LAST_WAIT = 16'(BUS_TIMEOUT_CYCLES - 1);

    state_t      state;
    state_t      eff_state;
    logic [15:0] wait_count;
    logic        mem_stall;
    logic        bus_done;
    logic        enter_abort;
    logic        take_exception;
    logic [5:0]  stall_raw;

    // While reset is held the register may still hold a stale state, so the
    // combinational stall view treats it as IDLE.
    assign eff_state = reset ? IDLE : state;
    assign mem_stall = ctrl.mem_request & ~ctrl.bus_ready & (eff_state != ABORT);
    assign bus_done  = ctrl.bus_ready | ~ctrl.mem_request;

    assign enter_abort    = (state == WAIT) & ~bus_done & (wait_count == LAST_WAIT);
    assign take_exception = ctrl.exception_valid & ~ctrl.flush;

    // Each hazard holds its own stage and everything upstream; WB is never held
    // so the latch below the lowest held stage always takes a bubble.
    assign stall_raw = ({6{ctrl.id_stall_request}} & 6'b000111)
                     | ({6{ctrl.ex_stall_request}} & 6'b001111)
                     | ({6{mem_stall}}             & 6'b011111);
    assign ctrl.stall = ctrl.flush ? 6'b000000 : stall_raw;

    always_ff @(posedge clock) begin
        if (reset) begin
            state                  <= IDLE;
            wait_count             <= 16'd0;
            ctrl.flush             <= 1'b0;
            ctrl.bus_timeout       <= 1'b0;
            ctrl.new_pc            <= 32'd0;
            ctrl.stall_cycle_count <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (ctrl.mem_request & ~ctrl.bus_ready) begin
                        state      <= WAIT;
                        wait_count <= 16'd1;
                    end
                end
                WAIT: begin
                    if (bus_done) begin
                        state      <= IDLE;
                        wait_count <= 16'd0;
                    end else if (wait_count == LAST_WAIT) begin
                        state <= ABORT;
                    end else begin
                        wait_count <= wait_count + 16'd1;
                    end
                end
                default: begin
                    state      <= IDLE;
                    wait_count <= 16'd0;
                end
            endcase
            // A bus abort takes priority over a coincident exception.
            ctrl.flush       <= enter_abort | take_exception;
            ctrl.bus_timeout <= enter_abort;
            if (enter_abort)
                ctrl.new_pc <= BUS_ERROR_VECTOR;
            else if (take_exception)
                ctrl.new_pc <= ctrl.exception_handler_address;
            if (ctrl.stall[0] && ctrl.stall_cycle_count != 32'hFFFF_FFFF)
                ctrl.stall_cycle_count <= ctrl.stall_cycle_count + 32'd1;
        end
    end
endmodule

// File: tb/tb_pipeline_controller.sv
// tb_pipeline_controller: table-driven and sequence checks of pipeline_controller via a due-cycle scoreboard
module tb_pipeline_controller;
    logic clock;
    logic reset;

    pipeline_controller_if pif ();

    pipeline_controller #(
        .BUS_TIMEOUT_CYCLES(4),
        .BUS_ERROR_VECTOR  (32'h0000_0180)
    ) dut (
        .clock(clock),
        .reset(reset),
        .ctrl (pif)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic       id;
        logic       ex;
        logic       mr;
        logic       rdy;
        logic [5:0] stall;
    } vec_t;

    typedef struct {
        int          due;
        int          sel;
        logic [31:0] exp;
        string       name;
    } exp_t;

    vec_t        vecs[10];
    exp_t        sb[$];
    int          cyc = 0;
    int          compared = 0;
    int          mismatched = 0;
    logic [31:0] model_cnt = 32'd0;

    function automatic logic [31:0] actual(input int sel);
        case (sel)
            0:       return {26'd0, pif.stall};
            1:       return {31'd0, pif.flush};
            2:       return pif.new_pc;
            3:       return {31'd0, pif.bus_timeout};
            default: return pif.stall_cycle_count;
        endcase
    endfunction

    task automatic push(input int due, input int sel, input logic [31:0] exp, input string name);
        exp_t e;
        e.due  = due;
        e.sel  = sel;
        e.exp  = exp;
        e.name = name;
        sb.push_back(e);
    endtask

    // Drives one cycle of inputs, queues the expected combinational stall for
    // this cycle and the expected counter after the coming edge, then retires
    // every expectation that has come due.
    task automatic tick(input logic id, input logic ex, input logic mr, input logic rdy,
                        input logic exc, input logic [31:0] addr, input logic rst,
                        input logic [5:0] es, input string tag);
        exp_t        e;
        logic [31:0] act;
        @(negedge clock);
        cyc++;
        reset                         = rst;
        pif.id_stall_request          = id;
        pif.ex_stall_request          = ex;
        pif.mem_request               = mr;
        pif.bus_ready                 = rdy;
        pif.exception_valid           = exc;
        pif.exception_handler_address = addr;
        push(cyc, 0, {26'd0, es}, {tag, "_stall"});
        model_cnt = rst ? 32'd0 : model_cnt + {31'd0, es[0]};
        push(cyc + 1, 4, model_cnt, {tag, "_count"});
        #1;
        while (sb.size() > 0 && sb[0].due <= cyc) begin
            e   = sb.pop_front();
            act = actual(e.sel);
            compared++;
            if (act !== e.exp) begin
                mismatched++;
                $display("FAIL %s (cycle %0d): got %h expected %h", e.name, cyc, act, e.exp);
            end
        end
    endtask

    // Registered outputs expected after the edge that ends the current cycle.
    task automatic expect_reg(input logic f, input logic t, input logic [31:0] pc, input string tag);
        push(cyc + 1, 1, {31'd0, f}, {tag, "_flush"});
        push(cyc + 1, 3, {31'd0, t}, {tag, "_timeout"});
        push(cyc + 1, 2, pc, {tag, "_newpc"});
    endtask

    initial begin
        reset                         = 1'b1;
        pif.id_stall_request          = 1'b0;
        pif.ex_stall_request          = 1'b0;
        pif.mem_request               = 1'b0;
        pif.bus_ready                 = 1'b0;
        pif.exception_valid           = 1'b0;
        pif.exception_handler_address = 32'd0;

        vecs[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 6'b000000};
        vecs[1] = '{1'b1, 1'b0, 1'b0, 1'b0, 6'b000111};
        vecs[2] = '{1'b0, 1'b1, 1'b0, 1'b0, 6'b001111};
        vecs[3] = '{1'b0, 1'b0, 1'b1, 1'b0, 6'b011111};
        vecs[4] = '{1'b0, 1'b0, 1'b1, 1'b1, 6'b000000};
        vecs[5] = '{1'b1, 1'b1, 1'b0, 1'b0, 6'b001111};
        vecs[6] = '{1'b1, 1'b0, 1'b1, 1'b0, 6'b011111};
        vecs[7] = '{1'b0, 1'b0, 1'b0, 1'b1, 6'b000000};
        vecs[8] = '{1'b1, 1'b1, 1'b1, 1'b0, 6'b011111};
        vecs[9] = '{1'b0, 1'b0, 1'b0, 1'b0, 6'b000000};

        tick(0, 0, 0, 0, 0, 32'd0, 1, 6'b000000, "reset0");
        tick(0, 0, 0, 0, 0, 32'd0, 1, 6'b000000, "reset1");
        expect_reg(0, 0, 32'd0, "reset");

        for (int i = 0; i < 10; i++) begin
            tick(vecs[i].id, vecs[i].ex, vecs[i].mr, vecs[i].rdy, 0, 32'd0, 0, vecs[i].stall,
                 $sformatf("vec%0d", i));
            expect_reg(0, 0, 32'd0, $sformatf("vec%0d", i));
        end

        // Bus timeout with a coincident exception that must be dropped; the
        // abort cycle also ignores id stall and a further exception.
        for (int i = 0; i < 3; i++) begin
            tick(0, 0, 1, 0, 0, 32'd0, 0, 6'b011111, $sformatf("to_wait%0d", i));
            expect_reg(0, 0, 32'd0, $sformatf("to_wait%0d", i));
        end
        tick(0, 0, 1, 0, 1, 32'hDEAD_BEEF, 0, 6'b011111, "to_last");
        expect_reg(1, 1, 32'h0000_0180, "to_abort");
        tick(1, 0, 1, 0, 1, 32'h1111_1111, 0, 6'b000000, "to_abortcyc");
        expect_reg(0, 0, 32'h0000_0180, "to_after");
        tick(0, 0, 0, 0, 0, 32'd0, 0, 6'b000000, "to_idle");
        expect_reg(0, 0, 32'h0000_0180, "to_idle");

        // Bus completes after three waits; a fresh request afterwards must
        // restart the timeout rather than abort early.
        for (int i = 0; i < 3; i++) begin
            tick(0, 0, 1, 0, 0, 32'd0, 0, 6'b011111, $sformatf("rdy_wait%0d", i));
            expect_reg(0, 0, 32'h0000_0180, $sformatf("rdy_wait%0d", i));
        end
        tick(0, 0, 1, 1, 0, 32'd0, 0, 6'b000000, "rdy_done");
        expect_reg(0, 0, 32'h0000_0180, "rdy_done");
        for (int i = 0; i < 3; i++) begin
            tick(0, 0, 1, 0, 0, 32'd0, 0, 6'b011111, $sformatf("rdy_again%0d", i));
            expect_reg(0, 0, 32'h0000_0180, $sformatf("rdy_again%0d", i));
        end
        tick(0, 0, 0, 0, 0, 32'd0, 0, 6'b000000, "rdy_drop");
        expect_reg(0, 0, 32'h0000_0180, "rdy_drop");

        // Exception during an EX stall; a second exception in the flush cycle is ignored.
        tick(0, 1, 0, 0, 1, 32'hBFC0_0380, 0, 6'b001111, "exc_req");
        expect_reg(1, 0, 32'hBFC0_0380, "exc_flush");
        tick(0, 1, 0, 0, 1, 32'h1234_5678, 0, 6'b000000, "exc_flushcyc");
        expect_reg(0, 0, 32'hBFC0_0380, "exc_ignored");
        tick(0, 1, 0, 0, 0, 32'd0, 0, 6'b001111, "exc_after");
        expect_reg(0, 0, 32'hBFC0_0380, "exc_after");
        tick(0, 0, 0, 0, 0, 32'd0, 0, 6'b000000, "exc_idle");
        expect_reg(0, 0, 32'hBFC0_0380, "exc_idle");

        // Reset in the second WAIT cycle: everything clears, no abort follows.
        tick(0, 0, 1, 0, 0, 32'd0, 0, 6'b011111, "rst_w0");
        expect_reg(0, 0, 32'hBFC0_0380, "rst_w0");
        tick(0, 0, 1, 0, 0, 32'd0, 0, 6'b011111, "rst_w1");
        expect_reg(0, 0, 32'hBFC0_0380, "rst_w1");
        tick(0, 0, 1, 0, 0, 32'd0, 1, 6'b011111, "rst_w2");
        expect_reg(0, 0, 32'd0, "rst_hit");
        for (int i = 0; i < 5; i++) begin
            tick(0, 0, 0, 0, 0, 32'd0, 0, 6'b000000, $sformatf("rst_after%0d", i));
            expect_reg(0, 0, 32'd0, $sformatf("rst_after%0d", i));
        end
        tick(0, 0, 0, 0, 0, 32'd0, 0, 6'b000000, "drain");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
